// File: rtl/accumulation_controller.sv
// -----------------------------------------------------------------------------
// accumulation_controller
//   Sequential stage after the combinational triplet adder. Owns the running
//   sum for one image: accepts NUM_TRIPLETS signed product triplets, adds the
//   bias, compares the result against a threshold and reports the cat/no-cat
//   decision with a one-cycle done pulse.
//
// Ports
//   clk        in   rising-edge clock
//   resetN     in   asynchronous active-low reset
//   start      in   1-cycle pulse, begins a new image (honoured only in IDLE)
//   valid_in   in   Result1..3 valid this cycle
//   in_ready   out  a triplet is accepted this cycle when valid_in is high
//   Result1..3 in   signed products (PW bits), channels R/G/B
//   bias       in   signed bias, sampled in BIAS
//   threshold  in   signed threshold, sampled in DECIDE
//   busy       out  high in ACCUM/BIAS/DECIDE
//   done       out  1-cycle pulse, decision valid
//   cat        out  1 = total > threshold (signed), held until next decision
//   total      out  final signed sum, held until next decision
//   overflow   out  sticky flag, some add in this image left RESULT_WIDTH range
// -----------------------------------------------------------------------------
module accumulation_controller #(
  parameter int PIXEL_WIDTH      = 8,
  parameter int WEIGHT_PRECISION = 5,
  parameter int RESULT_WIDTH     = 32,
  parameter int NUM_TRIPLETS     = 1024,
  localparam int PW = 2*(WEIGHT_PRECISION+PIXEL_WIDTH)+1,
  localparam int CW = $clog2(NUM_TRIPLETS+1)
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           start,
  input  logic                           valid_in,
  output logic                           in_ready,
  input  logic signed [PW-1:0]           Result1,
  input  logic signed [PW-1:0]           Result2,
  input  logic signed [PW-1:0]           Result3,
  input  logic signed [RESULT_WIDTH-1:0] bias,
  input  logic signed [RESULT_WIDTH-1:0] threshold,
  output logic                           busy,
  output logic                           done,
  output logic                           cat,
  output logic signed [RESULT_WIDTH-1:0] total,
  output logic                           overflow
);

  // Extended width used to detect that an add left the RESULT_WIDTH range.
  localparam int SW = RESULT_WIDTH + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] BIAS   = 2'd2;
  localparam logic [1:0] DECIDE = 2'd3;

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_TRIPLETS - 1);

  logic [1:0]                    state;
  logic signed [RESULT_WIDTH-1:0] acc;
  logic [CW-1:0]                 count;
  logic signed [SW-1:0]          triplet_sum;
  logic signed [SW-1:0]          bias_sum;

  // Sign-extend a product to the extended sum width.
  function automatic logic signed [SW-1:0] sext_prod(input logic signed [PW-1:0] v);
    return SW'(v);
  endfunction

  // Sign-extend a RESULT_WIDTH value to the extended sum width.
  function automatic logic signed [SW-1:0] sext_res(input logic signed [RESULT_WIDTH-1:0] v);
    return SW'(v);
  endfunction

  // The result fits RESULT_WIDTH only when the top three bits agree.
  function automatic logic out_of_range(input logic [SW-1:0] s);
    return !((s[SW-1:SW-3] == 3'b000) || (s[SW-1:SW-3] == 3'b111));
  endfunction

  assign triplet_sum = sext_res(acc) + sext_prod(Result1) + sext_prod(Result2)
                     + sext_prod(Result3);
  assign bias_sum    = sext_res(acc) + sext_res(bias);

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      total    <= '0;
      cat      <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        ACCUM: begin
          if (valid_in) begin
            acc   <= triplet_sum[RESULT_WIDTH-1:0];
            count <= count + CW'(1);
            if (out_of_range(triplet_sum)) overflow <= 1'b1;
            if (count == LAST_IDX) state <= BIAS;
          end
        end
        BIAS: begin
          acc <= bias_sum[RESULT_WIDTH-1:0];
          if (out_of_range(bias_sum)) overflow <= 1'b1;
          state <= DECIDE;
        end
        DECIDE: begin
          total <= acc;
          cat   <= (acc > threshold);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulation_controller.sv
module tb_accumulation_controller;

  localparam int PW = 33;
  localparam int RW = 32;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  start;
  logic                  valid_in;
  logic                  in_ready;
  logic signed [PW-1:0]  Result1, Result2, Result3;
  logic signed [RW-1:0]  bias, threshold;
  logic                  busy, done, cat, overflow;
  logic signed [RW-1:0]  total;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  accumulation_controller #(
    .PIXEL_WIDTH(8), .WEIGHT_PRECISION(8), .RESULT_WIDTH(RW), .NUM_TRIPLETS(4)
  ) dut (
    .clk(clk), .resetN(resetN), .start(start), .valid_in(valid_in),
    .in_ready(in_ready), .Result1(Result1), .Result2(Result2), .Result3(Result3),
    .bias(bias), .threshold(threshold), .busy(busy), .done(done), .cat(cat),
    .total(total), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Runs one image: start pulse, n triplets (optionally gapped), waits for done.
  task automatic run_image(input logic signed [PW-1:0] r1, r2, r3,
                           input bit gap, input int mid_start, input bit extra_valid,
                           input logic signed [RW-1:0] b, thr,
                           output int acc_cnt, output int lat,
                           output logic done_next, output logic ready_after);
    int i;
    int last_cyc;
    bias = b; threshold = thr;
    acc_cnt = 0; lat = -1; last_cyc = 0; i = 0; done_next = 1'bx;
    @(negedge clk); start = 1'b1;
    while (acc_cnt < 4 && i < 100) begin
      @(negedge clk);
      start    = (i == mid_start);
      valid_in = gap ? (i % 3 == 0) : 1'b1;
      Result1 = r1; Result2 = r2; Result3 = r3;
      if (valid_in && in_ready) begin
        acc_cnt++;
        last_cyc = cyc;
      end
      i++;
    end
    @(negedge clk);
    start = 1'b0;
    valid_in = extra_valid;
    ready_after = in_ready;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        lat = cyc - last_cyc;
        break;
      end
      @(negedge clk);
      valid_in = 1'b0;
    end
    @(negedge clk);
    done_next = done;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'($urandom); valid_in = 1'($urandom);
      Result1 = PW'($urandom); Result2 = PW'($urandom); Result3 = PW'($urandom);
      bias = RW'($urandom); threshold = RW'($urandom);
      checks++;
      if ({done, cat, overflow, busy, in_ready} !== 5'b0 || total !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: flags=%b total=%0d, expected flags=00000 total=0",
                 k, {done, cat, overflow, busy, in_ready}, total);
      end
    end
    @(negedge clk);
    start = 1'b0; valid_in = 1'b0; resetN = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b done=%b, expected 0 0 0",
               in_ready, busy, done);
    end
  endtask

  task automatic test_nominal();
    int n, lat; logic dn, rdy;
    run_image(33'sd10, 33'sd20, 33'sd30, 1'b0, -1, 1'b0, -32'sd100, 32'sd100, n, lat, dn, rdy);
    checks++; if (n !== 4) begin errors++; $display("FAIL nom_accepts: got %0d want 4", n); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL nom_latency: got %0d want 3", lat); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL nom_done_pulse: done=%b want 0", dn); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL nom_ready_in_bias: got %b want 0", rdy); end
    checks++; if (total !== 32'sd140) begin errors++; $display("FAIL nom_total: got %0d want 140", total); end
    checks++; if (cat !== 1'b1) begin errors++; $display("FAIL nom_cat: got %b want 1", cat); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL nom_overflow: got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_gaps();
    int n, lat; logic dn, rdy;
    run_image(33'sd10, 33'sd20, 33'sd30, 1'b1, -1, 1'b1, -32'sd100, 32'sd100, n, lat, dn, rdy);
    checks++; if (n !== 4) begin errors++; $display("FAIL gap_accepts: got %0d want 4", n); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL gap_fifth_valid_ready: got %b want 0", rdy); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL gap_latency: got %0d want 3", lat); end
    checks++; if (total !== 32'sd140) begin errors++; $display("FAIL gap_total: got %0d want 140", total); end
    // valid_in in IDLE must not disturb anything
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); valid_in = 1'b1;
    end
    @(negedge clk); valid_in = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || total !== 32'sd140) begin
      errors++;
      $display("FAIL idle_valid_ignored: busy=%b rdy=%b done=%b total=%0d, expected 0 0 0 140",
               busy, in_ready, done, total);
    end
  endtask

  task automatic test_signed_threshold();
    int n, lat; logic dn, rdy;
    run_image(-33'sd50, -33'sd50, -33'sd50, 1'b0, -1, 1'b0, 32'sd0, -32'sd600, n, lat, dn, rdy);
    checks++; if (total !== -32'sd600) begin errors++; $display("FAIL sgn_total: got %0d want -600", total); end
    checks++; if (cat !== 1'b0) begin errors++; $display("FAIL sgn_cat_eq: got %b want 0", cat); end
    run_image(-33'sd50, -33'sd50, -33'sd50, 1'b0, -1, 1'b0, 32'sd0, -32'sd601, n, lat, dn, rdy);
    checks++; if (total !== -32'sd600) begin errors++; $display("FAIL sgn_total2: got %0d want -600", total); end
    checks++; if (cat !== 1'b1) begin errors++; $display("FAIL sgn_cat_gt: got %b want 1", cat); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sgn_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    int n, lat; logic dn, rdy;
    // 4 * 2^31 = 2^33, which wraps to 0 modulo 2^32
    run_image(33'sd1073741824, 33'sd1073741824, 33'sd0, 1'b0, -1, 1'b0, 32'sd0, 32'sd0,
              n, lat, dn, rdy);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (total !== 32'sd0) begin errors++; $display("FAIL ovf_total: got %0d want 0", total); end
    checks++; if (cat !== 1'b0) begin errors++; $display("FAIL ovf_cat: got %b want 0", cat); end
    @(negedge clk); @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky_idle: got %b want 1", overflow); end
    bias = 32'sd0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_cleared_on_start: ovf=%b busy=%b rdy=%b, expected 0 1 1",
               overflow, busy, in_ready);
    end
    valid_in = 1'b1; Result1 = 33'sd1; Result2 = 33'sd1; Result3 = 33'sd1;
    repeat (4) @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (total !== 32'sd12 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_next_image: total=%0d ovf=%b, expected 12 0", total, overflow);
    end
  endtask

  task automatic test_abort_ignore();
    int n, lat; logic dn, rdy;
    run_image(33'sd10, 33'sd20, 33'sd30, 1'b0, 1, 1'b0, -32'sd100, 32'sd100, n, lat, dn, rdy);
    checks++;
    if (total !== 32'sd140 || n !== 4 || lat !== 3) begin
      errors++;
      $display("FAIL mid_start_ignored: total=%0d accepts=%0d lat=%0d, expected 140 4 3",
               total, n, lat);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; valid_in = 1'b1;
    @(negedge clk);
    @(negedge clk); valid_in = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_mid_accum_state: busy=%b rdy=%b, expected 1 1", busy, in_ready);
    end
    resetN = 1'b0;
    #1;
    checks++;
    if ({done, cat, overflow, busy, in_ready} !== 5'b0 || total !== '0) begin
      errors++;
      $display("FAIL abort_outputs: flags=%b total=%0d, expected flags=00000 total=0",
               {done, cat, overflow, busy, in_ready}, total);
    end
    @(negedge clk); resetN = 1'b1;
    run_image(33'sd1, 33'sd2, 33'sd3, 1'b0, -1, 1'b0, 32'sd0, 32'sd0, n, lat, dn, rdy);
    checks++;
    if (total !== 32'sd24 || cat !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL abort_fresh_image: total=%0d cat=%b lat=%0d, expected 24 1 3",
               total, cat, lat);
    end
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; valid_in = 1'b0;
    Result1 = '0; Result2 = '0; Result3 = '0; bias = '0; threshold = '0;
    test_reset();
    test_nominal();
    test_gaps();
    test_signed_threshold();
    test_overflow();
    test_abort_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
